ex_mem_stage: RTL and testbench

// - EX->MEM pipeline register directly downstream of the ALU. Captures alu_res with the

---
 rtl/common_pkg.sv | 22 ++
 rtl/ex_mem_stage.sv | 169 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the EX->MEM pipeline register.
// State encoding and the stage bundle carried into MEM.
package common_pkg;

    typedef enum logic [1:0] {
        EX_RUN,
        EX_WAIT,
        EX_DRAIN
    } ex_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic        rd_is_float;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] store_data;
        logic [31:0] alu_res;
    } ex_mem_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: absorbs multi-cycle ALU ops with bubbles,
// stalls upstream while they run and feeds EX->ID forwarding.
module ex_mem_stage
    import common_pkg::*;
#(
    parameter int MAX_WAIT = 40,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic             in_rd_is_float,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic [31:0]      in_store_data,
    input  logic [31:0]      alu_res,
    input  logic             alu_insert_bubble,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_alu_res,
    output logic [31:0]      out_store_data,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_rd_is_float,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             stall_upstream,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic             fwd_is_float,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] bubble_count,
    output logic             err_timeout
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

    ex_state_t         state_q, state_d;
    ex_mem_t           out_q, out_d;
    ex_mem_t           meta_q, meta_d;
    ex_mem_t           in_cap;
    logic              vld_q, vld_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic              err_q, err_d;

    // x0 is hardwired: integer writes to it are dropped at capture
    always_comb begin
        in_cap.pc          = in_pc;
        in_cap.rd          = in_rd;
        in_cap.reg_write   = in_reg_write
                           && ((in_rd != 5'd0) || in_rd_is_float);
        in_cap.rd_is_float = in_rd_is_float;
        in_cap.mem_read    = in_mem_read;
        in_cap.mem_write   = in_mem_write;
        in_cap.store_data  = in_store_data;
        in_cap.alu_res     = alu_res;
    end

    assign wcnt_inc = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        meta_d  = meta_q;
        vld_d   = vld_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            EX_RUN: begin
                if (flush) begin
                    vld_d = 1'b0;
                end else if (!mem_ready) begin
                    vld_d = vld_q;
                end else if (in_valid && !alu_insert_bubble) begin
                    out_d = in_cap;
                    vld_d = 1'b1;
                end else if (in_valid) begin
                    meta_d  = in_cap;
                    vld_d   = 1'b0;
                    wcnt_d  = '0;
                    state_d = EX_WAIT;
                end else begin
                    vld_d = 1'b0;
                end
            end
            EX_WAIT: begin
                vld_d  = 1'b0;
                bcnt_d = bcnt_q + CNT_W'(1);
                wcnt_d = wcnt_inc;
                if (flush) begin
                    wcnt_d  = '0;
                    state_d = EX_DRAIN;
                end else if (!alu_insert_bubble && mem_ready) begin
                    out_d         = meta_q;
                    out_d.alu_res = alu_res;
                    vld_d         = 1'b1;
                    state_d       = EX_RUN;
                end
            end
            EX_DRAIN: begin
                vld_d  = 1'b0;
                wcnt_d = wcnt_inc;
                if (!alu_insert_bubble) begin
                    state_d = EX_RUN;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = EX_RUN;
            end
        endcase
        err_d = err_q || (wcnt_d == WCNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EX_RUN;
            out_q   <= '0;
            meta_q  <= '0;
            vld_q   <= 1'b0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            meta_q  <= meta_d;
            vld_q   <= vld_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        if (flush && state_q == EX_RUN) begin
            stall_upstream = 1'b0;
        end else begin
            stall_upstream = (state_q == EX_RUN && in_valid && alu_insert_bubble)
                           || (state_q != EX_RUN) || !mem_ready;
        end
    end

    assign out_valid       = vld_q;
    assign out_pc          = out_q.pc;
    assign out_alu_res     = out_q.alu_res;
    assign out_store_data  = out_q.store_data;
    assign out_rd          = out_q.rd;
    assign out_reg_write   = out_q.reg_write;
    assign out_rd_is_float = out_q.rd_is_float;
    assign out_mem_read    = out_q.mem_read;
    assign out_mem_write   = out_q.mem_write;

    assign fwd_valid    = vld_q && out_q.reg_write && !out_q.mem_read;
    assign fwd_rd       = out_q.rd;
    assign fwd_is_float = out_q.rd_is_float;
    assign fwd_data     = out_q.alu_res;

    assign bubble_count = bcnt_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: capture, multi-cycle ops, flush/drain,
// backpressure, x0 rule, forwarding and the sticky timeout.
module tb_ex_mem_stage;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_rd_is_float;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [31:0] in_store_data;
    logic [31:0] alu_res;
    logic        alu_insert_bubble;
    logic        flush;
    logic        mem_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_alu_res;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_rd_is_float;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        stall_upstream;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic        fwd_is_float;
    logic [31:0] fwd_data;
    logic [31:0] bubble_count;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    ex_mem_stage #(.MAX_WAIT(40), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_rd_is_float(in_rd_is_float),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_store_data(in_store_data), .alu_res(alu_res),
        .alu_insert_bubble(alu_insert_bubble), .flush(flush),
        .mem_ready(mem_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_alu_res(out_alu_res), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_rd_is_float(out_rd_is_float), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .stall_upstream(stall_upstream),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_is_float(fwd_is_float),
        .fwd_data(fwd_data), .bubble_count(bubble_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [4:0] rd,
                          input logic wr, input logic fl,
                          input logic [31:0] res);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_rd          = rd;
        in_reg_write   = wr;
        in_rd_is_float = fl;
        in_mem_read    = 1'b0;
        in_mem_write   = 1'b0;
        in_store_data  = pc ^ 32'hA5A5_0000;
        alu_res        = res;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_rd = '0; in_reg_write = 1'b0;
        in_rd_is_float = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_store_data = '0; alu_res = '0; alu_insert_bubble = 1'b0;
        flush = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_bcnt", bubble_count, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_stall", stall_upstream, 0);

        // single-cycle ADD
        set_op(32'h100, 5'd5, 1'b1, 1'b0, 32'h12);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_rd", out_rd, 5);
        chk("add_pc", out_pc, 32'h100);
        chk("add_sd", out_store_data, 32'hA5A5_0100);
        chk("add_fwd_valid", fwd_valid, 1);
        chk("add_fwd_data", fwd_data, 32'h12);

        // x0 rule
        set_op(32'h104, 5'd0, 1'b1, 1'b0, 32'hFF);
        tick();
        chk("x0_int_wr", out_reg_write, 0);
        chk("x0_int_fwd", fwd_valid, 0);
        set_op(32'h108, 5'd0, 1'b1, 1'b1, 32'hFF);
        tick();
        chk("x0_flt_wr", out_reg_write, 1);
        chk("x0_flt_fwd", fwd_valid, 1);
        chk("x0_flt_isf", fwd_is_float, 1);

        // backpressure holds the registered instruction
        set_op(32'h200, 5'd6, 1'b1, 1'b0, 32'h77);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall", stall_upstream, 1);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_pc", out_pc, 32'h108);
            chk("bp_res", out_alu_res, 32'hFF);
        end
        mem_ready = 1'b1;
        tick();
        chk("bp_release_pc", out_pc, 32'h200);
        chk("bp_release_res", out_alu_res, 32'h77);

        // MUL: six busy cycles then result
        set_op(32'h300, 5'd7, 1'b1, 1'b0, 32'hDEAD);
        alu_insert_bubble = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("mul_stall", stall_upstream, 1);
            tick();
            chk("mul_bubble", out_valid, 0);
        end
        alu_insert_bubble = 1'b0;
        alu_res = 32'h30;
        tick();
        chk("mul_valid", out_valid, 1);
        chk("mul_res", out_alu_res, 32'h30);
        chk("mul_rd", out_rd, 7);
        chk("mul_pc", out_pc, 32'h300);
        chk("mul_bcnt", bubble_count, 6);
        in_valid = 1'b0;
        tick();
        chk("mul_after_valid", out_valid, 0);
        chk("mul_after_stall", stall_upstream, 0);

        // DIV flushed on its third busy cycle
        set_op(32'h400, 5'd8, 1'b1, 1'b0, 32'h0);
        alu_insert_bubble = 1'b1;
        tick(); tick();
        flush = 1'b1;
        #1;
        chk("div_flush_stall", stall_upstream, 1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick(); tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_bcnt", bubble_count, 8);
        alu_insert_bubble = 1'b0;
        alu_res = 32'h99;
        #1;
        chk("drain_stall", stall_upstream, 1);
        tick();
        chk("drain_exit_valid", out_valid, 0);
        set_op(32'h500, 5'd3, 1'b1, 1'b0, 32'h55);
        #1;
        chk("post_drain_stall", stall_upstream, 0);
        tick();
        chk("post_drain_valid", out_valid, 1);
        chk("post_drain_res", out_alu_res, 32'h55);
        chk("post_drain_bcnt", bubble_count, 8);

        // flush in RUN beats mem_ready=0
        set_op(32'h600, 5'd4, 1'b1, 1'b0, 32'h66);
        flush = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("run_flush_stall", stall_upstream, 0);
        tick();
        chk("run_flush_valid", out_valid, 0);
        flush = 1'b0;
        mem_ready = 1'b1;

        // load does not forward
        set_op(32'h700, 5'd9, 1'b1, 1'b0, 32'h1000);
        in_mem_read = 1'b1;
        tick();
        chk("ld_valid", out_valid, 1);
        chk("ld_mem_read", out_mem_read, 1);
        chk("ld_fwd", fwd_valid, 0);

        // stuck ALU: timeout after 41 busy cycles
        set_op(32'h800, 5'd10, 1'b1, 1'b0, 32'h0);
        alu_insert_bubble = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (39) tick();
        chk("to_40_err", err_timeout, 0);
        tick();
        chk("to_41_err", err_timeout, 1);
        repeat (5) tick();
        chk("to_sticky_busy", err_timeout, 1);
        alu_insert_bubble = 1'b0;
        repeat (3) tick();
        chk("to_sticky_run", err_timeout, 1);

        // reset in the middle of WAIT
        set_op(32'h900, 5'd11, 1'b1, 1'b0, 32'h0);
        alu_insert_bubble = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        alu_insert_bubble = 1'b0;
        #1;
        chk("rst_wait_err", err_timeout, 0);
        chk("rst_wait_valid", out_valid, 0);
        chk("rst_wait_pc", out_pc, 0);
        chk("rst_wait_bcnt", bubble_count, 0);
        chk("rst_wait_stall", stall_upstream, 0);
        tick();
        chk("rst_wait_run", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
